// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped BTB with 2-bit saturating counters (BHT).
//               One-cycle registered prediction path, in-order update path
//               with registered mispredict/redirect, and running counts of
//               resolved branches and mispredictions.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               pred_req/pred_pc    - prediction request from fetch
//               pred_valid/hit/taken/target - registered prediction result
//               upd_*               - resolved conditional branch
//               mispredict/redirect_pc - registered redirect pulse
//               branch_cnt/mispred_cnt - wrapping 32-bit statistics
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pred_req,
    input  logic [31:0] pred_pc,
    output logic        pred_valid,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int TAG_W = 30 - IDX_W;

    localparam logic [1:0] C_CTR_RESET = 2'b01;
    localparam logic [1:0] C_CTR_ALLOC = 2'b10;
    localparam logic [1:0] C_CTR_MAX   = 2'b11;
    localparam logic [1:0] C_CTR_MIN   = 2'b00;

    // ------------------------------------------------------------------
    // Table storage
    // ------------------------------------------------------------------
    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];

    // ------------------------------------------------------------------
    // Index / tag extraction (PC bits [1:0] are always word-aligned zero)
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_pred_idx;
    logic [TAG_W-1:0] w_pred_tag;
    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_unused_pc_bits;

    assign w_pred_idx = pred_pc[IDX_W+1:2];
    assign w_pred_tag = pred_pc[31:IDX_W+2];
    assign w_upd_idx  = upd_pc[IDX_W+1:2];
    assign w_upd_tag  = upd_pc[31:IDX_W+2];
    assign w_unused_pc_bits = &{1'b0, pred_pc[1:0], upd_pc[1:0]};

    // ------------------------------------------------------------------
    // Prediction lookup: reads the table as it stands before this
    // cycle's update, giving read-before-write on same-index collisions.
    // ------------------------------------------------------------------
    logic        w_pred_hit;
    logic        w_pred_taken;
    logic [31:0] w_pred_target;

    assign w_pred_hit    = r_valid[w_pred_idx] && (r_tag[w_pred_idx] == w_pred_tag);
    assign w_pred_taken  = w_pred_hit && r_ctr[w_pred_idx][1];
    assign w_pred_target = w_pred_taken ? r_target[w_pred_idx] : (pred_pc + 32'd4);

    // ------------------------------------------------------------------
    // Update-side decode
    // ------------------------------------------------------------------
    logic        w_upd_hit;
    logic        w_mispredict;
    logic [31:0] w_redirect_pc;

    assign w_upd_hit     = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    assign w_mispredict  = (upd_taken != upd_pred_taken) ||
                           (upd_taken && (upd_target != upd_pred_target));
    assign w_redirect_pc = upd_taken ? upd_target : (upd_pc + 32'd4);

    // ------------------------------------------------------------------
    // Table update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= C_CTR_RESET;
            end
        end else if (upd_valid) begin
            if (w_upd_hit) begin
                if (upd_taken) begin
                    if (r_ctr[w_upd_idx] != C_CTR_MAX) begin
                        r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + 2'd1;
                    end
                    r_target[w_upd_idx] <= upd_target;
                end else if (r_ctr[w_upd_idx] != C_CTR_MIN) begin
                    r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                // Taken miss evicts whatever occupies the slot.
                r_valid[w_upd_idx]  <= 1'b1;
                r_tag[w_upd_idx]    <= w_upd_tag;
                r_target[w_upd_idx] <= upd_target;
                r_ctr[w_upd_idx]    <= C_CTR_ALLOC;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered prediction outputs (zeroed when no request)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid  <= 1'b0;
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
        end else begin
            pred_valid  <= pred_req;
            pred_hit    <= pred_req && w_pred_hit;
            pred_taken  <= pred_req && w_pred_taken;
            pred_target <= pred_req ? w_pred_target : 32'd0;
        end
    end

    // ------------------------------------------------------------------
    // Registered redirect and statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict  <= 1'b0;
            redirect_pc <= '0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            mispredict  <= upd_valid && w_mispredict;
            redirect_pc <= (upd_valid && w_mispredict) ? w_redirect_pc : 32'd0;
            if (upd_valid) begin
                branch_cnt <= branch_cnt + 32'd1;
                if (w_mispredict) begin
                    mispred_cnt <= mispred_cnt + 32'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Self-checking bench for branch_predictor. Directed scenarios
//               followed by randomized traffic, all compared against a
//               behavioural table model kept in the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pred_req = 1'b0;
    logic [31:0] pred_pc = '0;
    logic        pred_valid, pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_pred_taken = 1'b0;
    logic [31:0] upd_pred_target = '0;
    logic        mispredict;
    logic [31:0] redirect_pc, branch_cnt, mispred_cnt;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst),
        .pred_req(pred_req), .pred_pc(pred_pc),
        .pred_valid(pred_valid), .pred_hit(pred_hit),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: one slot per index, holding the owning PC's upper
    // part as a plain number and the confidence as an integer 0..3.
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] m_bcnt, m_mcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = 0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        m_bcnt = '0;
        m_mcnt = '0;
    endtask

    // One clock cycle: drive, predict outcome from the model, advance, compare.
    task automatic step(input bit r, input bit preq, input logic [31:0] ppc,
                        input bit uv, input logic [31:0] upc, input bit ut,
                        input logic [31:0] utgt, input bit upt, input logic [31:0] uptgt);
        int          pi, ui;
        int unsigned ptag, utag;
        bit          e_pv, e_hit, e_tk, e_mis, hit_u;
        logic [31:0] e_tgt, e_red;
        @(negedge clk);
        rst = r; pred_req = preq; pred_pc = ppc;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
        upd_pred_taken = upt; upd_pred_target = uptgt;
        e_pv = 0; e_hit = 0; e_tk = 0; e_tgt = '0; e_mis = 0; e_red = '0;
        if (r) begin
            model_reset();
        end else begin
            pi   = int'((ppc / 4) % ENTRIES);
            ptag = ppc / (4 * ENTRIES);
            if (preq) begin
                e_pv  = 1;
                e_hit = m_valid[pi] && (m_tag[pi] == ptag);
                e_tk  = e_hit && (m_ctr[pi] >= 2);
                e_tgt = e_tk ? m_tgt[pi] : ppc + 32'd4;
            end
            if (uv) begin
                ui    = int'((upc / 4) % ENTRIES);
                utag  = upc / (4 * ENTRIES);
                e_mis = (ut != upt) || (ut && (utgt != uptgt));
                e_red = e_mis ? (ut ? utgt : upc + 32'd4) : 32'd0;
                m_bcnt = m_bcnt + 32'd1;
                if (e_mis) m_mcnt = m_mcnt + 32'd1;
                hit_u = m_valid[ui] && (m_tag[ui] == utag);
                if (hit_u && ut) begin
                    m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
                    m_tgt[ui] = utgt;
                end else if (hit_u) begin
                    m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
                end else if (ut) begin
                    m_valid[ui] = 1; m_tag[ui] = utag; m_tgt[ui] = utgt; m_ctr[ui] = 2;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("pred_valid",  {31'd0, pred_valid}, {31'd0, e_pv});
        chk("pred_hit",    {31'd0, pred_hit},   {31'd0, e_hit});
        chk("pred_taken",  {31'd0, pred_taken}, {31'd0, e_tk});
        chk("pred_target", pred_target, e_tgt);
        chk("mispredict",  {31'd0, mispredict}, {31'd0, e_mis});
        chk("redirect_pc", redirect_pc, e_red);
        chk("branch_cnt",  branch_cnt,  m_bcnt);
        chk("mispred_cnt", mispred_cnt, m_mcnt);
    endtask

    task automatic do_pred(input logic [31:0] pc);
        step(0, 1, pc, 0, '0, 0, '0, 0, '0);
    endtask

    task automatic do_upd(input logic [31:0] pc, input bit t, input logic [31:0] tgt,
                          input bit pt, input logic [31:0] ptgt);
        step(0, 0, '0, 1, pc, t, tgt, pt, ptgt);
    endtask

    initial begin
        model_reset();

        // Reset, with requests and updates presented that must be ignored.
        step(1, 1, 32'h100, 1, 32'h100, 1, 32'h80, 0, '0);
        step(1, 0, '0, 0, '0, 0, '0, 0, '0);
        step(0, 0, '0, 0, '0, 0, '0, 0, '0);

        // Cold miss.
        do_pred(32'h100);
        chk("cold_target", pred_target, 32'h104);

        // Allocate via mispredicting taken update, then hit.
        do_upd(32'h100, 1, 32'h80, 0, '0);
        chk("alloc_redirect", redirect_pc, 32'h80);
        chk("alloc_mcnt", mispred_cnt, 32'd1);
        do_pred(32'h100);
        chk("alloc_target", pred_target, 32'h80);

        // Three not-taken updates drive the counter to 0.
        do_upd(32'h100, 0, '0, 1, 32'h80);
        do_upd(32'h100, 0, '0, 0, '0);
        do_upd(32'h100, 0, '0, 0, '0);
        do_pred(32'h100);
        chk("nt_hit_target", pred_target, 32'h104);
        // Saturation at 0: one taken update must bring it only to 1 (not taken).
        do_upd(32'h100, 0, '0, 0, '0);
        do_upd(32'h100, 1, 32'h80, 0, '0);
        do_pred(32'h100);
        // Four more taken updates saturate at 3; one not-taken keeps it taken.
        for (int i = 0; i < 4; i++) do_upd(32'h100, 1, 32'h90, 1, 32'h90);
        do_upd(32'h100, 0, '0, 1, 32'h90);
        do_pred(32'h100);
        chk("sat3_target", pred_target, 32'h90);

        // Aliasing on the same index with a different tag.
        do_upd(32'h140, 1, 32'h300, 0, '0);
        do_pred(32'h100);
        do_pred(32'h140);
        chk("alias_target", pred_target, 32'h300);

        // Same-cycle read-before-write.
        step(0, 1, 32'h200, 1, 32'h200, 1, 32'h400, 0, '0);
        chk("rbw_hit", {31'd0, pred_hit}, 32'd0);
        do_pred(32'h200);
        chk("rbw_next_hit", {31'd0, pred_hit}, 32'd1);

        // Back-to-back updates, then reset right after a mispredict.
        do_upd(32'h204, 1, 32'h10, 0, '0);
        do_upd(32'h208, 1, 32'h20, 0, '0);
        step(1, 1, 32'h140, 0, '0, 0, '0, 0, '0);
        step(0, 0, '0, 0, '0, 0, '0, 0, '0);
        do_pred(32'h140);
        chk("post_rst_miss", {31'd0, pred_hit}, 32'd0);

        // Randomized traffic on a small PC pool so hits and aliases recur.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ppc, upc, tgt, ptgt;
            ppc  = ($urandom_range(0, 1) ? 32'h8000_0000 : 32'h0) |
                   (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
            upc  = ($urandom_range(0, 1) ? 32'h8000_0000 : 32'h0) |
                   (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
            tgt  = 32'($urandom_range(0, 3)) << 4;
            ptgt = 32'($urandom_range(0, 3)) << 4;
            step(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), ppc,
                 1'($urandom_range(0, 1)), upc, 1'($urandom_range(0, 1)), tgt,
                 1'($urandom_range(0, 1)), ptgt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
